rvcore_rob: RTL and testbench
=============================

RVCORE_ROB -- requirements
Module: rvcore_rob

Interface
REQ-001 SHALL have parameter DISPATCH_WIDTH, default 2, lanes per dispatch/writeback/commit group and banks per ROB row.
REQ-002 SHALL have parameter ROB_ADDR_WIDTH, default 4, row index width; ROB_DEPTH = 2**ROB_ADDR_WIDTH rows.
REQ-003 SHALL have parameter PHYS_REGS_ADDR_WIDTH, default 6, physical register tag width.
REQ-004 SHALL be clocked by a single clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 dispatch_en[i]  input  1 per lane  lane i allocates an entry this cycle.
REQ-008 dispatch_phys_rd[i]  input  PHYS_REGS_ADDR_WIDTH per lane  destination physical tag.
REQ-009 dispatch_arch_rd[i]  input  5 per lane  destination architectural register.
REQ-010 dispatch_bank_addr[i]  output  DISPATCH_WIDTH per lane  bank of allocated entry.
REQ-011 dispatch_rob_addr[i]  output  ROB_ADDR_WIDTH per lane  row of allocated entry.
REQ-012 full  output  1  no free row; dispatch refused.
REQ-013 writeback_en[i], writeback_bank_addr[i], writeback_rob_addr[i]  input  1 / DISPATCH_WIDTH / ROB_ADDR_WIDTH per lane  completion marks.
REQ-014 commit_en[i], commit_phys_rd[i], commit_arch_rd[i]  output  1 / PHYS_REGS_ADDR_WIDTH / 5 per lane  retiring entries.

Function
REQ-015 Storage: ROB_DEPTH rows x DISPATCH_WIDTH banks; entry = {valid, done, phys_rd, arch_rd}.
REQ-016 head, tail: ROB_ADDR_WIDTH+1 bits incl. wrap bit; empty = (head==tail); full = (tail-head)==ROB_DEPTH, from registered state only.
REQ-017 dispatch_rob_addr[i] = tail[ROB_ADDR_WIDTH-1:0], dispatch_bank_addr[i] = i, combinational, valid every cycle.
REQ-018 Row accepted iff any dispatch_en and !full: at edge, entry i gets valid=dispatch_en[i], done=0, tags; tail+1 (wraps modulo 2*ROB_DEPTH).
REQ-019 Dispatch while full: entirely ignored, no state change; all dispatch_en low: tail unchanged.
REQ-020 writeback_en[i]: sets done of entry (writeback_rob_addr[i], writeback_bank_addr[i]) at edge; ignored if entry not valid; multiple lanes same cycle all apply.
REQ-021 Head row committable iff !empty and every valid entry in it has done=1.
REQ-022 When committable: commit_en[i]=valid[i], commit tags = entry fields, combinational from registered state; at edge row cleared, head+1.
REQ-023 Not committable: all commit_en=0, commit_phys_rd/commit_arch_rd=0.
REQ-024 Latency: writeback at edge N of last pending head entry -> commit_en high in cycle following edge N; dispatch-to-commit minimum 2 edges.
REQ-025 Simultaneous dispatch+commit: both apply; when full, dispatch still refused that cycle even if commit frees a row.
REQ-026 Row commits all-or-nothing, lanes in bank order; no partial-row retire.

Reset
REQ-027 rst_n low asynchronously clears head, tail, all valid/done bits; full=0, commit_en=0, commit tags=0.
REQ-028 Reset mid-operation discards all in-flight entries; first dispatch after release lands in row 0.

Configuration
REQ-029 Macro ROB_FLUSH_EN: defined -> input port flush (1 bit); flush high at edge clears all valid/done, head=tail=0, overrides dispatch and writeback that cycle; commit_en forced 0 while flush high.
REQ-030 ROB_FLUSH_EN undefined -> no flush port; state cleared only by rst_n.

Verification
REQ-031 Reset, dispatch row {lane0 phys 5 arch 1, lane1 phys 6 arch 2} -> rob_addr 0, banks 0/1; no commit until both written back; then commit_en=11, tags 5/1,6/2 same cycle.
REQ-032 Dispatch lane0 only, writeback row 0 bank 0 -> commit_en=01 next cycle, head=1.
REQ-033 Dispatch 16 rows (ROB_ADDR_WIDTH=4), no writeback -> full=1; 17th dispatch ignored, tail unchanged; commit row 0 -> full=0, next dispatch gets rob_addr 0 (wrap).
REQ-034 Writeback row 1 complete before row 0 -> no commit until row 0 done, then rows 0 and 1 on consecutive cycles.
REQ-035 rst_n low mid-stream with 3 rows pending -> commit_en=0, full=0 immediately; next dispatch rob_addr 0.
REQ-036 ROB_FLUSH_EN: flush with 5 rows pending plus same-cycle dispatch -> all empty, tail=0, no commit.

Source files
------------

// File: rtl/rvcore_rob_if.sv
`default_nettype none
// ============================================================================
// Module   : rvcore_rob_if
// Brief    : Dispatch / writeback / commit bundle of the reorder buffer.
// Revision : 1.0
// ============================================================================
interface rvcore_rob_if #(
    parameter int DISPATCH_WIDTH       = 2,
    parameter int ROB_ADDR_WIDTH       = 4,
    parameter int PHYS_REGS_ADDR_WIDTH = 6
);
    logic [DISPATCH_WIDTH-1:0]                                dispatch_en;
    logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]      dispatch_phys_rd;
    logic [DISPATCH_WIDTH-1:0][4:0]                           dispatch_arch_rd;
    logic [DISPATCH_WIDTH-1:0][DISPATCH_WIDTH-1:0]            dispatch_bank_addr;
    logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]            dispatch_rob_addr;
    logic                                                     full;

    logic [DISPATCH_WIDTH-1:0]                                writeback_en;
    logic [DISPATCH_WIDTH-1:0][DISPATCH_WIDTH-1:0]            writeback_bank_addr;
    logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]            writeback_rob_addr;

    logic [DISPATCH_WIDTH-1:0]                                commit_en;
    logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]      commit_phys_rd;
    logic [DISPATCH_WIDTH-1:0][4:0]                           commit_arch_rd;

    modport master (
        output dispatch_en, dispatch_phys_rd, dispatch_arch_rd,
        output writeback_en, writeback_bank_addr, writeback_rob_addr,
        input  dispatch_bank_addr, dispatch_rob_addr, full,
        input  commit_en, commit_phys_rd, commit_arch_rd
    );

    modport slave (
        input  dispatch_en, dispatch_phys_rd, dispatch_arch_rd,
        input  writeback_en, writeback_bank_addr, writeback_rob_addr,
        output dispatch_bank_addr, dispatch_rob_addr, full,
        output commit_en, commit_phys_rd, commit_arch_rd
    );
endinterface
`default_nettype wire

// File: rtl/rvcore_rob.sv
`default_nettype none
// ============================================================================
// Module   : rvcore_rob
// Brief    : Banked reorder buffer; one row per dispatch group, in-order
//            all-or-nothing row retirement. Optional ROB_FLUSH_EN adds a
//            synchronous flush input that empties the buffer.
// Revision : 1.0
// ============================================================================
module rvcore_rob #(
    parameter int DISPATCH_WIDTH       = 2,
    parameter int ROB_ADDR_WIDTH       = 4,
    parameter int PHYS_REGS_ADDR_WIDTH = 6
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
`ifdef ROB_FLUSH_EN
    input  wire logic   flush,
`endif
    rvcore_rob_if.slave rob_if
);
    localparam int c_ROB_DEPTH = 2 ** ROB_ADDR_WIDTH;

    typedef logic [ROB_ADDR_WIDTH:0]                           ptr_t;
    typedef logic [ROB_ADDR_WIDTH-1:0]                         row_t;
    typedef logic [DISPATCH_WIDTH-1:0]                         lane_bits_t;
    typedef logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys_row_t;
    typedef logic [DISPATCH_WIDTH-1:0][4:0]                    arch_row_t;

    localparam ptr_t c_FULL_DIST = ptr_t'(c_ROB_DEPTH);
    localparam ptr_t c_PTR_ONE   = ptr_t'(1);

    ptr_t       head_q, head_d;
    ptr_t       tail_q, tail_d;
    lane_bits_t valid_q [c_ROB_DEPTH];
    lane_bits_t valid_d [c_ROB_DEPTH];
    lane_bits_t done_q  [c_ROB_DEPTH];
    lane_bits_t done_d  [c_ROB_DEPTH];
    phys_row_t  phys_q  [c_ROB_DEPTH];
    phys_row_t  phys_d  [c_ROB_DEPTH];
    arch_row_t  arch_q  [c_ROB_DEPTH];
    arch_row_t  arch_d  [c_ROB_DEPTH];

    logic       w_flush;
    logic       w_empty;
    logic       w_full;
    logic       w_row_done;
    logic       w_commit;
    logic       w_dispatch;
    row_t       w_head_row;
    row_t       w_tail_row;

`ifdef ROB_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_head_row = head_q[ROB_ADDR_WIDTH-1:0];
    assign w_tail_row = tail_q[ROB_ADDR_WIDTH-1:0];

    // Wrap bit distinguishes full from empty when the row indices coincide.
    assign w_empty    = (head_q == tail_q);
    assign w_full     = ((tail_q - head_q) == c_FULL_DIST);

    assign w_row_done = &(~valid_q[w_head_row] | done_q[w_head_row]);
    assign w_commit   = !w_empty && w_row_done && !w_flush;
    assign w_dispatch = (|rob_if.dispatch_en) && !w_full;

    assign rob_if.full = w_full;

    generate
        for (genvar l = 0; l < DISPATCH_WIDTH; l++) begin : g_lane
            assign rob_if.dispatch_rob_addr[l]  = w_tail_row;
            assign rob_if.dispatch_bank_addr[l] = DISPATCH_WIDTH'(l);
            assign rob_if.commit_en[l]          = w_commit & valid_q[w_head_row][l];
            assign rob_if.commit_phys_rd[l]     = w_commit ? phys_q[w_head_row][l] : '0;
            assign rob_if.commit_arch_rd[l]     = w_commit ? arch_q[w_head_row][l] : '0;
        end
    endgenerate

    // Later updates take priority: writeback, then commit, then dispatch, then flush.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        done_d  = done_q;
        phys_d  = phys_q;
        arch_d  = arch_q;

        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            if (rob_if.writeback_en[l]) begin
                for (int b = 0; b < DISPATCH_WIDTH; b++) begin
                    if ((rob_if.writeback_bank_addr[l] == DISPATCH_WIDTH'(b)) &&
                        valid_q[rob_if.writeback_rob_addr[l]][b]) begin
                        done_d[rob_if.writeback_rob_addr[l]][b] = 1'b1;
                    end
                end
            end
        end

        if (w_commit) begin
            valid_d[w_head_row] = '0;
            done_d[w_head_row]  = '0;
            head_d              = head_q + c_PTR_ONE;
        end

        if (w_dispatch) begin
            valid_d[w_tail_row] = rob_if.dispatch_en;
            done_d[w_tail_row]  = '0;
            phys_d[w_tail_row]  = rob_if.dispatch_phys_rd;
            arch_d[w_tail_row]  = rob_if.dispatch_arch_rd;
            tail_d              = tail_q + c_PTR_ONE;
        end

        if (w_flush) begin
            for (int r = 0; r < c_ROB_DEPTH; r++) begin
                valid_d[r] = '0;
                done_d[r]  = '0;
            end
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            for (int r = 0; r < c_ROB_DEPTH; r++) begin
                valid_q[r] <= '0;
                done_q[r]  <= '0;
                phys_q[r]  <= '0;
                arch_q[r]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            phys_q  <= phys_d;
            arch_q  <= arch_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvcore_rob.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvcore_rob
// Brief    : Randomized bench for rvcore_rob against a queue-of-rows model.
// Revision : 1.0
// ============================================================================
module tb_rvcore_rob;
    localparam int c_DW    = 2;
    localparam int c_RA    = 4;
    localparam int c_PW    = 6;
    localparam int c_DEPTH = 16;

    typedef struct packed {
        logic [1:0]        v;
        logic [1:0]        d;
        logic [1:0][5:0]   p;
        logic [1:0][4:0]   a;
    } mrow_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    mrow_t model_q[$];
    int    m_head = 0;
    int    m_tail = 0;

    rvcore_rob_if #(
        .DISPATCH_WIDTH       (c_DW),
        .ROB_ADDR_WIDTH       (c_RA),
        .PHYS_REGS_ADDR_WIDTH (c_PW)
    ) rob_if ();

    rvcore_rob #(
        .DISPATCH_WIDTH       (c_DW),
        .ROB_ADDR_WIDTH       (c_RA),
        .PHYS_REGS_ADDR_WIDTH (c_PW)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef ROB_FLUSH_EN
        .flush  (flush),
`endif
        .rob_if (rob_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rob_if.dispatch_en         = '0;
        rob_if.dispatch_phys_rd    = '0;
        rob_if.dispatch_arch_rd    = '0;
        rob_if.writeback_en        = '0;
        rob_if.writeback_bank_addr = '0;
        rob_if.writeback_rob_addr  = '0;
        flush                      = 1'b0;
    endtask

    task automatic model_clear();
        model_q.delete();
        m_head = 0;
        m_tail = 0;
    endtask

    // One clock: drive at negedge, check outputs, then advance the model at posedge.
    task automatic step(input logic [1:0] den, input logic [1:0][5:0] dp, input logic [1:0][4:0] da,
                        input logic [1:0] wen, input logic [1:0][1:0] wbank,
                        input logic [1:0][3:0] wrob, input logic fl);
        logic       exp_full;
        logic       can_commit;
        logic [1:0] exp_cen;
        int         pos;
        mrow_t      r;
        @(negedge clk);
        rob_if.dispatch_en         = den;
        rob_if.dispatch_phys_rd    = dp;
        rob_if.dispatch_arch_rd    = da;
        rob_if.writeback_en        = wen;
        rob_if.writeback_bank_addr = wbank;
        rob_if.writeback_rob_addr  = wrob;
        flush                      = fl;
        #1;
        exp_full   = (model_q.size() == c_DEPTH);
        can_commit = (model_q.size() > 0) && !fl;
        if (can_commit) can_commit = ((model_q[0].v & ~model_q[0].d) == 2'b00);
        exp_cen    = can_commit ? model_q[0].v : 2'b00;
        check_val("full", rob_if.full, exp_full);
        check_val("commit_en", rob_if.commit_en, exp_cen);
        for (int i = 0; i < c_DW; i++) begin
            check_val("rob_addr", rob_if.dispatch_rob_addr[i], m_tail);
            check_val("bank_addr", rob_if.dispatch_bank_addr[i], i);
            if (!can_commit) begin
                check_val("commit_phys_idle", rob_if.commit_phys_rd[i], 0);
                check_val("commit_arch_idle", rob_if.commit_arch_rd[i], 0);
            end else if (model_q[0].v[i]) begin
                check_val("commit_phys", rob_if.commit_phys_rd[i], model_q[0].p[i]);
                check_val("commit_arch", rob_if.commit_arch_rd[i], model_q[0].a[i]);
            end
        end
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            for (int l = 0; l < c_DW; l++) begin
                pos = (int'(wrob[l]) - m_head + c_DEPTH) % c_DEPTH;
                if (wen[l] && wbank[l] < 2 && pos < model_q.size()) begin
                    if (model_q[pos].v[wbank[l]]) model_q[pos].d[wbank[l]] = 1'b1;
                end
            end
            if (can_commit) begin
                void'(model_q.pop_front());
                m_head = (m_head + 1) % c_DEPTH;
            end
            if (den != 2'b00 && !exp_full) begin
                r.v = den; r.d = 2'b00; r.p = dp; r.a = da;
                model_q.push_back(r);
                m_tail = (m_tail + 1) % c_DEPTH;
            end
        end
    endtask

    task automatic step_idle();
        step(2'b00, '0, '0, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic step_disp(input logic [1:0] den);
        step(den, {6'($urandom), 6'($urandom)}, {5'($urandom), 5'($urandom)}, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic step_wb_row(input logic [1:0] wen, input logic [3:0] row);
        step(2'b00, '0, '0, wen, {2'd1, 2'd0}, {row, row}, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check_val("rst_full", rob_if.full, 0);
        check_val("rst_commit_en", rob_if.commit_en, 0);
        check_val("rst_rob_addr", rob_if.dispatch_rob_addr[0], 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0]      den, wen;
        logic [1:0][1:0] wbank;
        logic [1:0][3:0] wrob;
        logic            fl;
        int              wb_pct, pos;

        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-lane row: commit only after both lanes are written back.
        step(2'b11, {6'd6, 6'd5}, {5'd2, 5'd1}, 2'b00, '0, '0, 1'b0);
        step_idle();
        step_wb_row(2'b01, 4'd0);
        step_idle();
        step_wb_row(2'b10, 4'd0);
        step_idle();
        step_idle();

        // Lane-0-only row.
        step_disp(2'b01);
        step_wb_row(2'b01, 4'd1);
        step_idle();
        step_idle();

        // Fill to full, refused dispatch, commit frees row 0, wrap.
        do_reset();
        repeat (17) step_disp(2'b11);
        step_wb_row(2'b11, 4'd0);
        step_disp(2'b11);
        step_disp(2'b11);
        step_idle();

        // Younger row completes first; retirement stays in order.
        do_reset();
        step_disp(2'b11);
        step_disp(2'b11);
        step_wb_row(2'b11, 4'd1);
        step_idle();
        step_idle();
        step_wb_row(2'b11, 4'd0);
        step_idle();
        step_idle();
        step_idle();

        // Reset with rows pending.
        step_disp(2'b11);
        step_disp(2'b10);
        step_disp(2'b01);
        do_reset();
        step_disp(2'b11);
        step_idle();

`ifdef ROB_FLUSH_EN
        repeat (5) step_disp(2'b11);
        step(2'b11, '0, '0, 2'b11, {2'd1, 2'd0}, '0, 1'b1);
        step_idle();
        step_disp(2'b01);
`endif

        for (int c = 0; c < 4000; c++) begin
            if (c % 900 == 899) do_reset();
            wb_pct = ((c / 150) % 3 == 0) ? 5 : 60;
            den = 2'($urandom);
            if ($urandom_range(99) < 25) den = 2'b00;
            for (int l = 0; l < c_DW; l++) begin
                wen[l]   = 1'b0;
                wbank[l] = 2'($urandom);
                wrob[l]  = 4'($urandom);
                if (model_q.size() > 0 && $urandom_range(99) < wb_pct) begin
                    pos      = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(model_q.size() - 1));
                    wen[l]   = 1'b1;
                    wbank[l] = 2'($urandom_range(1));
                    wrob[l]  = 4'((m_head + pos) % c_DEPTH);
                end else if ($urandom_range(99) < 10) begin
                    wen[l] = 1'b1;
                end
            end
            fl = 1'b0;
`ifdef ROB_FLUSH_EN
            fl = ($urandom_range(199) == 0);
`endif
            step(den, {6'($urandom), 6'($urandom)}, {5'($urandom), 5'($urandom)}, wen, wbank, wrob, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
